icache: RTL

Direct-mapped, one-word-per-line instruction cache between the IF stage and `memctrl`. Serves IF fetch requests in one cycle on a hit. On a miss it issues a single 32-bit instruction read to `memctrl`, fills the line and returns the word. Removes repeated 4-byte-serial fetches from the memory port so `memctrl` is free for MEM loads and stores.

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_line_ram.sv | 45 ++++
 rtl/icache.sv | 128 ++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types, default geometry and address field helpers for the instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_INDEX_BITS = 7;
    localparam int DEF_ADDR_BITS  = 18;
    localparam int DEF_TAG_BITS   = DEF_ADDR_BITS - DEF_INDEX_BITS - 2;

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_bits);
        return (addr >> 2) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_bits,
                                             input int addr_bits);
        return (addr >> (index_bits + 2)) & ((32'd1 << (addr_bits - index_bits - 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Valid/tag/data line storage: combinational read, one synchronous write port,
// valid bits cleared by reset while tag and data keep their contents.
module icache_line_ram #(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [31:0]           rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [31:0]           wr_data_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (en_i && we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache sitting between IF and memctrl.
// Hits answer in one cycle; misses issue a single word read and fill the line.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        abort_in,
    output logic        if_done,
    output logic [31:0] if_instr,
    output logic        mc_read_or_not,
    output logic [31:0] mc_addr,
    input  logic        mc_load_done,
    input  logic [31:0] mc_instr
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

    state_e                state_q, state_d;
    logic                  drop_q, drop_d;
    logic                  done_q, done_d;
    logic                  rd_q, rd_d;
    logic [31:0]           instr_q, instr_d;
    logic [31:0]           mc_addr_q, mc_addr_d;

    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_BITS-1:0]   req_tag, wr_tag, line_tag;
    logic                  line_valid, hit, we;
    logic [31:0]           line_data;

    assign rd_idx  = INDEX_BITS'(addr_index(if_addr, INDEX_BITS));
    assign req_tag = TAG_BITS'(addr_tag(if_addr, INDEX_BITS, ADDR_BITS));
    // The fill targets the line of the registered miss address, not the live request.
    assign wr_idx  = INDEX_BITS'(addr_index(mc_addr_q, INDEX_BITS));
    assign wr_tag  = TAG_BITS'(addr_tag(mc_addr_q, INDEX_BITS, ADDR_BITS));
    assign hit     = line_valid && (line_tag == req_tag);

    icache_line_ram #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_line_ram (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .en_i      (rdy_in),
        .rd_idx_i  (rd_idx),
        .rd_valid_o(line_valid),
        .rd_tag_o  (line_tag),
        .rd_data_o (line_data),
        .we_i      (we),
        .wr_idx_i  (wr_idx),
        .wr_tag_i  (wr_tag),
        .wr_data_i (mc_instr)
    );

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        done_d    = 1'b0;
        rd_d      = rd_q;
        instr_d   = instr_q;
        mc_addr_d = mc_addr_q;
        we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req && !abort_in) begin
                    if (hit) begin
                        instr_d = line_data;
                        done_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        mc_addr_d = {if_addr[31:2], 2'b00};
                        rd_d      = 1'b1;
                        state_d   = MISS;
                    end
                end
            end
            MISS: begin
                if (mc_load_done) begin
                    // memctrl cannot cancel, so the line is filled even when the fetch was dropped.
                    we     = 1'b1;
                    rd_d   = 1'b0;
                    drop_d = 1'b0;
                    if (drop_q || abort_in) begin
                        state_d = IDLE;
                    end else begin
                        instr_d = mc_instr;
                        done_d  = 1'b1;
                        state_d = RESP;
                    end
                end else if (abort_in) begin
                    drop_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            drop_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            instr_q   <= '0;
            mc_addr_q <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            instr_q   <= instr_d;
            mc_addr_q <= mc_addr_d;
        end
    end

    assign if_done        = done_q;
    assign if_instr       = instr_q;
    assign mc_read_or_not = rd_q;
    assign mc_addr        = mc_addr_q;

endmodule
